alu_logic_serial: RTL and testbench



---
 rtl/alu_pkg.sv | 15 +
 rtl/logic_slice.sv | 23 ++
 rtl/alu_logic_serial.sv | 104 ++++++++++
 tb/tb_alu_logic_serial.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU datapath: logic op codes and serial FSM states.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/logic_slice.sv
// One slice of bitwise logic: AND/OR/XOR/NOR selected by op.
module logic_slice
  import alu_pkg::*;
#(
  parameter int slice = 8
) (
  input  logic [1:0]       op,
  input  logic [slice-1:0] a,
  input  logic [slice-1:0] b,
  output logic [slice-1:0] y
);

  always_comb begin
    y = '0;
    unique case (1'b1)
      (op == OP_AND): y = a & b;
      (op == OP_OR):  y = a | b;
      (op == OP_XOR): y = a ^ b;
      (op == OP_NOR): y = ~(a | b);
    endcase
  end

endmodule

// File: rtl/alu_logic_serial.sv
// Multicycle bitwise logic unit, slice bits per beat, LSB slice first.
// Optional registered zero flag: define ALU_LOGIC_SERIAL_ZERO_FLAG_EN.
module alu_logic_serial
  import alu_pkg::*;
#(
  parameter int size  = 32,
  parameter int slice = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] result,
  output logic            zero
);

  localparam int n  = size / slice;
  localparam int cw = (n > 1) ? $clog2(n) : 1;

  state_t          state;
  state_t          state_nx;
  logic [cw-1:0]   cnt;
  logic [1:0]      op_q;
  logic [size-1:0] a_q;
  logic [size-1:0] b_q;
  logic [size-1:0] acc;
  logic [size-1:0] acc_nx;
  logic [slice-1:0] sl_y;
  logic            last;
  logic            accept;

  assign last   = (cnt == cw'(n - 1));
  assign accept = start &&
                  ((state == ST_IDLE) || (state == ST_DONE));
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);

  logic_slice #(
    .slice(slice)
  ) u_slice (
    .op(op_q),
    .a (a_q[int'(cnt)*slice +: slice]),
    .b (b_q[int'(cnt)*slice +: slice]),
    .y (sl_y)
  );

  always_comb begin
    acc_nx = acc;
    acc_nx[int'(cnt)*slice +: slice] = sl_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      result <= '0;
    end else if (accept) begin
      cnt  <= '0;
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
      acc  <= '0;
    end else if (state == ST_RUN) begin
      acc <= acc_nx;
      cnt <= cnt + cw'(1);
      // result only ever sees a fully assembled word
      if (last) result <= acc_nx;
    end
  end

`ifdef ALU_LOGIC_SERIAL_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      zero <= 1'b0;
    else if (state == ST_RUN && last && !accept)
      zero <= (acc_nx == '0);
  end
`else
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_logic_serial.sv
// Directed bench for alu_logic_serial: vector table plus multicycle sequences.
module tb_alu_logic_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  logic       s_start = 1'b0;
  logic [1:0] s_op = 2'b00;
  logic [7:0] s_a = '0;
  logic [7:0] s_b = '0;
  logic       s_busy;
  logic       s_done;
  logic [7:0] s_result;
  logic       s_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_logic_serial #(.size(32), .slice(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .zero(zero)
  );

  alu_logic_serial #(.size(8), .slice(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op),
    .a(s_a), .b(s_b), .busy(s_busy), .done(s_done),
    .result(s_result), .zero(s_zero)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic zexp(input logic [31:0] r);
`ifdef ALU_LOGIC_SERIAL_ZERO_FLAG_EN
    return (r == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  // waits from a RUN cycle to DONE; counts busy cycles, flags overlap
  task automatic wait_done(output int nb, output logic ovl,
                           output logic tmo);
    nb = 0; ovl = 0; tmo = 1;
    for (int k = 0; k < 20; k++) begin
      if (busy && done) ovl = 1;
      if (done) begin tmo = 0; break; end
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic accept_op(input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  int   nb;
  logic ovl;
  logic tmo;
  int   gap;

  initial begin
    vecs[0] = '{2'b01, 32'h0F0F0F0F, 32'hF0F0F000, 32'hFFFFFF0F};
    vecs[1] = '{2'b11, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vecs[2] = '{2'b00, 32'h12345678, 32'h0000FFFF, 32'h00005678};
    vecs[3] = '{2'b10, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555};
    vecs[4] = '{2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000};
    vecs[5] = '{2'b10, 32'h12345678, 32'h12345678, 32'h00000000};
    vecs[6] = '{2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    vecs[7] = '{2'b01, 32'h80000001, 32'h00010000, 32'h80010001};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      accept_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(nb, ovl, tmo);
      chk($sformatf("v%0d_timeout", i), 32'(tmo), 32'd0);
      chk($sformatf("v%0d_busy_cycles", i), nb, 32'd4);
      chk($sformatf("v%0d_overlap", i), 32'(ovl), 32'd0);
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(zexp(vecs[i].res)));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // start during RUN is ignored; result holds old value
    accept_op(2'b00, 32'h12345678, 32'h0000FFFF);
    @(negedge clk);
    chk("run_hold_result", result, 32'h80010001);
    op = 2'b01; a = '0; b = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run_hold_result2", result, 32'h80010001);
    wait_done(nb, ovl, tmo);
    chk("ign_timeout", 32'(tmo), 32'd0);
    chk("ign_busy_cycles", nb, 32'd2);
    chk("ign_result", result, 32'h00005678);
    @(negedge clk);
    chk("ign_back_idle", 32'(busy), 32'd0);

    // back-to-back: start held through DONE
    op = 2'b10; a = 32'hAAAAAAAA; b = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    wait_done(nb, ovl, tmo);
    chk("b2b_first_result", result, 32'h55555555);
    @(negedge clk);
    start = 1'b0;
    a = '0; b = '0;
    chk("b2b_busy_again", 32'(busy), 32'd1);
    chk("b2b_no_done", 32'(done), 32'd0);
    gap = 1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_gap", gap, 32'd5);
    chk("b2b_second_result", result, 32'h55555555);
    @(negedge clk);

    // reset mid-run aborts immediately
    accept_op(2'b01, 32'h0000000F, 32'h000000F0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_idle", 32'(busy), 32'd0);
    accept_op(2'b01, 32'h0000000F, 32'h000000F0);
    wait_done(nb, ovl, tmo);
    chk("mrst_next_timeout", 32'(tmo), 32'd0);
    chk("mrst_next_busy", nb, 32'd4);
    chk("mrst_next_result", result, 32'h000000FF);

    // single-beat instance
    @(negedge clk);
    s_op = 2'b10; s_a = 8'hA5; s_b = 8'hFF; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("s_busy", 32'(s_busy), 32'd1);
    chk("s_done_early", 32'(s_done), 32'd0);
    @(negedge clk);
    chk("s_done", 32'(s_done), 32'd1);
    chk("s_busy_off", 32'(s_busy), 32'd0);
    chk("s_result", 32'(s_result), 32'h5A);
    chk("s_zero", 32'(s_zero), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
